// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - two-read one-write register file with post-reset clear sweep
// Optional feature: define REGFILE_BYPASS_EN for write-first forwarding to the read ports.
// Reads are registered (one cycle latency); entry 0 is hardwired to zero when ZERO_REG=1.
module regfile_2r1w #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ren,
  input  logic [ADDR_W-1:0] ra_sel,
  input  logic [ADDR_W-1:0] rb_sel,
  input  logic              we,
  input  logic [ADDR_W-1:0] wsel,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_ra_data;
  logic [DATA_W-1:0] r_rb_data;
  logic              r_busy;

  logic              w_wr_en;
  logic              w_last_clr;
  logic [DATA_W-1:0] w_ra_val;
  logic [DATA_W-1:0] w_rb_val;

  // A write to entry 0 is dropped when it is the hardwired zero register.
  assign w_wr_en    = we && !((ZERO_REG != 0) && (wsel == '0));
  assign w_last_clr = (r_clr_cnt == {ADDR_W{1'b1}});

  // Read-port value selection: zero register, optional forwarding, else stored contents.
  always_comb begin
    w_ra_val = r_mem[ra_sel];
    w_rb_val = r_mem[rb_sel];
    if ((ZERO_REG != 0) && (ra_sel == '0)) w_ra_val = '0;
    if ((ZERO_REG != 0) && (rb_sel == '0)) w_rb_val = '0;
`ifdef REGFILE_BYPASS_EN
    if (w_wr_en && (ra_sel == wsel)) w_ra_val = wdata;
    if (w_wr_en && (rb_sel == wsel)) w_rb_val = wdata;
`endif
  end

  // Control FSM: clear sweep after reset, then registered reads in READY.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
      r_ra_data <= '0;
      r_rb_data <= '0;
      r_busy    <= 1'b1;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
          if (w_last_clr) begin
            r_state <= S_READY;
            r_busy  <= 1'b0;
          end
        end
        S_READY: begin
          if (ren) begin
            r_ra_data <= w_ra_val;
            r_rb_data <= w_rb_val;
          end
        end
        default: begin
          r_state <= S_CLEAR;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  // Storage: the sweep zeroes one entry per cycle; the write port is live only in READY.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_CLEAR) begin
        r_mem[r_clr_cnt] <= '0;
      end else if (w_wr_en) begin
        r_mem[wsel] <= wdata;
      end
    end
  end

  assign ra_data = r_ra_data;
  assign rb_data = r_rb_data;
  assign busy    = r_busy;

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb/tb_regfile_2r1w.sv - directed bench for regfile_2r1w, ZERO_REG=1 and ZERO_REG=0 side by side
// Honours REGFILE_BYPASS_EN when the design is built with it.
module tb_regfile_2r1w;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk;
  logic          rst;
  logic          ren;
  logic [AW-1:0] ra_sel;
  logic [AW-1:0] rb_sel;
  logic          we;
  logic [AW-1:0] wsel;
  logic [DW-1:0] wdata;
  logic [DW-1:0] ra0, rb0, ra1, rb1;
  logic          busy0, busy1;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_2r1w #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) u_dut_z (
    .clk(clk), .rst(rst), .ren(ren), .ra_sel(ra_sel), .rb_sel(rb_sel),
    .we(we), .wsel(wsel), .wdata(wdata),
    .ra_data(ra0), .rb_data(rb0), .busy(busy0)
  );

  regfile_2r1w #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) u_dut_n (
    .clk(clk), .rst(rst), .ren(ren), .ra_sel(ra_sel), .rb_sel(rb_sel),
    .we(we), .wsel(wsel), .wdata(wdata),
    .ra_data(ra1), .rb_data(rb1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem [DEPTH];
  int            m_clr_left = 0;
  bit            m_valid    = 1'b0;
  logic [DW-1:0] m_ra0, m_rb0, m_ra1, m_rb1;

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a, input bit zero_reg);
    logic [DW-1:0] v;
    v = (zero_reg && a == 0) ? '0 : m_mem[a];
`ifdef REGFILE_BYPASS_EN
    if (we && a == wsel && !(zero_reg && wsel == 0)) v = wdata;
`endif
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid    = 1'b1;
      m_clr_left = DEPTH;
      m_ra0 = '0; m_rb0 = '0; m_ra1 = '0; m_rb1 = '0;
    end else if (m_valid && m_clr_left > 0) begin
      m_mem[DEPTH - m_clr_left] = '0;
      m_clr_left--;
    end else if (m_valid) begin
      if (ren) begin
        m_ra0 = m_read(ra_sel, 1'b1);
        m_rb0 = m_read(rb_sel, 1'b1);
        m_ra1 = m_read(ra_sel, 1'b0);
        m_rb1 = m_read(rb_sel, 1'b0);
      end
      if (we) m_mem[wsel] = wdata;
    end
  end

  // Every-cycle comparison against the model once reset has been seen.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy_z", {7'd0, busy0}, {7'd0, m_clr_left > 0});
      chk("busy_n", {7'd0, busy1}, {7'd0, m_clr_left > 0});
      chk("ra_z", ra0, m_ra0);
      chk("rb_z", rb0, m_rb0);
      chk("ra_n", ra1, m_ra1);
      chk("rb_n", rb1, m_rb1);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    we = 1'b0; ren = 1'b0; wsel = '0; wdata = '0; ra_sel = '0; rb_sel = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; wsel = a; wdata = d; ren = 1'b0;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [AW-1:0] b);
    ren = 1'b1; ra_sel = a; rb_sel = b;
    tick();
    ren = 1'b0;
  endtask

  // Counts edges until busy falls; called right after rst is released.
  task automatic count_busy(output int n);
    n = 0;
    while (busy0 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset(input int edges);
    rst = 1'b1;
    repeat (edges) tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    idle();
    tick(); tick();
    rst = 1'b0;

    // Clear sweep length after release
    count_busy(n);
    chk("busy_len_initial", 8'(n), 8'd32);

    // Every address reads zero after the sweep
    for (int i = 0; i < DEPTH; i++) begin
      rd(AW'(i), AW'(DEPTH - 1 - i));
      chk("clear_read", ra1, 8'h00);
    end

    // Basic write then read on both ports, then hold with ren=0
    wr(5'd3, 8'hA5);
    wr(5'd7, 8'h5A);
    rd(5'd3, 5'd7);
    chk("rd_r3", ra0, 8'hA5);
    chk("rd_r7", rb0, 8'h5A);
    ra_sel = 5'd0; rb_sel = 5'd1;
    tick(); tick();
    chk("hold_a", ra0, 8'hA5);
    chk("hold_b", rb0, 8'h5A);

    // Same select on both ports
    rd(5'd7, 5'd7);
    chk("same_sel", rb1, 8'h5A);

    // Zero register
    wr(5'd0, 8'hFF);
    rd(5'd0, 5'd0);
    chk("zero_reg_on", ra0, 8'h00);
    chk("zero_reg_off", ra1, 8'hFF);

    // Same-cycle read/write collision
    wr(5'd4, 8'h11);
    we = 1'b1; wsel = 5'd4; wdata = 8'h22; ren = 1'b1; ra_sel = 5'd4; rb_sel = 5'd3;
    tick();
    we = 1'b0; ren = 1'b0;
`ifdef REGFILE_BYPASS_EN
    chk("collide_fwd", ra0, 8'h22);
`else
    chk("collide_old", ra0, 8'h11);
`endif
    rd(5'd4, 5'd4);
    chk("collide_next", ra0, 8'h22);

    // Collision on entry 0: never forwarded when it is the zero register
    we = 1'b1; wsel = 5'd0; wdata = 8'h44; ren = 1'b1; ra_sel = 5'd0; rb_sel = 5'd0;
    tick();
    idle();
    chk("collide_zero", ra0, 8'h00);

    // Fill all entries with a pattern while reading the previous one, then read back
    for (int i = 0; i < DEPTH; i++) begin
      we = 1'b1; wsel = AW'(i); wdata = DW'(i * 7 + 1);
      ren = 1'b1; ra_sel = AW'(i - 1); rb_sel = AW'(i);
      tick();
    end
    idle();
    for (int i = 0; i < DEPTH; i++) rd(AW'(i), AW'(i ^ 5'h1F));
    rd(5'd10, 5'd31);
    chk("pattern_r10", ra0, 8'd71);
    chk("pattern_r31", rb0, 8'd218);

    // Writes and reads ignored during the clear sweep
    do_reset(1);
    we = 1'b1; wsel = 5'd5; wdata = 8'h33; ren = 1'b1; ra_sel = 5'd3; rb_sel = 5'd4;
    tick();
    idle();
    chk("clear_ra_zero", ra0, 8'h00);
    count_busy(n);
    chk("busy_len_reset", 8'(n + 1), 8'd32);
    rd(5'd5, 5'd3);
    chk("busy_write_dropped", ra0, 8'h00);
    chk("cleared_r3", rb0, 8'h00);

    // Reset part-way through the sweep restarts it
    do_reset(1);
    repeat (10) tick();
    do_reset(1);
    count_busy(n);
    chk("busy_len_restart", 8'(n), 8'd32);

    // Reset in READY forces a full clear
    wr(5'd9, 8'h77);
    rd(5'd9, 5'd9);
    chk("r9_written", ra0, 8'h77);
    do_reset(1);
    count_busy(n);
    chk("busy_len_ready_rst", 8'(n), 8'd32);
    rd(5'd9, 5'd9);
    chk("r9_cleared", ra1, 8'h00);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parametrised successor to the single-port register bank.
- Provides two synchronous read ports and one write port, with a hardwired zero register.
- A post-reset clear sequencer zeroes every entry, so no entry is ever undefined.
- Feeds ALU operand A/B in the datapath; the write port is driven by writeback.

Parameters:
- DATA_W, 8, width of each register in bits.
- ADDR_W, 5, select width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1, when 1, entry 0 reads as zero and ignores writes; when 0, entry 0 is an ordinary register.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ren  in  1  read enable; 0 holds both read outputs.
- ra_sel  in  ADDR_W  read port A select.
- rb_sel  in  ADDR_W  read port B select.
- we  in  1  write enable.
- wsel  in  ADDR_W  write select.
- wdata  in  DATA_W  write data.
- ra_data  out  DATA_W  registered read data, port A.
- rb_data  out  DATA_W  registered read data, port B.
- busy  out  1  high while reset or the clear sequence is active; writes and reads are ignored while high.

Behaviour:
- Reset is synchronous and active-high. Any edge with rst=1 sets:
  - state to CLEAR, clr_cnt to 0;
  - ra_data and rb_data to 0;
  - busy to 1.
  - Memory contents are not touched in that cycle.
- CLEAR state (rst=0):
  - Each edge writes mem[clr_cnt] <= 0 and increments clr_cnt.
  - On the edge where clr_cnt == DEPTH-1, state goes to READY and busy goes to 0.
  - busy therefore deasserts exactly DEPTH edges after the first edge with rst=0.
  - In CLEAR, we, ren and the selects are ignored, and ra_data/rb_data stay 0.
- READY state:
  - Write: on an edge with we=1, mem[wsel] <= wdata. If ZERO_REG=1 and wsel==0, the write is discarded.
  - Read latency is 1 cycle. On an edge with ren=1:
    - ra_data <= value(ra_sel) and rb_data <= value(rb_sel);
    - value(x) = 0 when ZERO_REG=1 and x==0, otherwise mem[x] as held before this edge's write.
  - On an edge with ren=0, ra_data and rb_data hold their previous values.
  - ra_sel == rb_sel is legal; both ports return the same value.
- Simultaneous read and write to the same address, without the bypass feature: the read returns the old contents and the new value is visible from the next read.
- Reset mid-CLEAR restarts the sweep from entry 0. Reset in READY forces a full clear.
- No other state exists. clr_cnt is ADDR_W bits wide and wraps only on the CLEAR→READY transition.
- No arithmetic is performed; data passes unmodified at DATA_W bits.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in READY, when we=1 and ren=1 and a read select equals wsel, that port loads wdata on the same edge (write-first forwarding). Both ports forward independently.
  - With ZERO_REG=1 and wsel==0, there is no forwarding and the port still reads 0.
  - There is no forwarding in CLEAR.
- Undefined: read-first behaviour as described above. The forwarding mux and comparators are absent.

Test Plan:
- Reset release: hold rst=1 for 2 edges, then 0 (defaults: DEPTH=32).
  - busy=1 for exactly 32 edges after release, then 0.
  - Reading every address returns 0x00.
- Write/read: write 0xA5→r3 and 0x5A→r7; next cycle ren=1, ra_sel=3, rb_sel=7.
  - After one edge, ra_data=0xA5 and rb_data=0x5A.
  - With ren=0 on the following edges, both hold.
- Zero register: write 0xFF→r0, then read ra_sel=0 → ra_data=0x00.
  - Repeat with ZERO_REG=0 → ra_data=0xFF.
- Same-cycle collision: r4 holds 0x11; on one edge, write 0x22→r4 with ra_sel=4, ren=1.
  - Without REGFILE_BYPASS_EN: ra_data=0x11, then the next read gives 0x22.
  - With the macro: ra_data=0x22 on the same edge.
- Writes ignored while busy: pulse we=1 wsel=5 wdata=0x33 during CLEAR → after busy falls, r5 reads 0x00.
- Reset mid-operation:
  - Assert rst at clear count 10 → busy stays high for a further full 32 edges after release.
  - Assert rst in READY after writing r9=0x77 → r9 reads 0x00 after the new clear completes.
